rob_commit_unit: RTL and testbench

Reorder buffer and in-order commit stage of the out-of-order core. It allocates one entry per renamed instruction in program order and hands the entry index back to decode as the instruction tag. It marks entries complete from the common data bus and retires at most one completed instruction per cycle from the head. Retirement drives the commit channel consumed by the architectural register file and by the rename free-list.

---
 rtl/rob_commit_unit.sv | 123 ++++++++++++
 tb/tb_rob_commit_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order retirement of one done entry per cycle; alloc tag is the tail index.
// Alloc-to-commit is at least 2 cycles. Alloc is refused while full, and the flags come from registered pointers only.
module rob_commit_unit #(
    parameter int ROB_DEPTH  = 16,
    parameter int TAG_W      = 4,
    parameter int PHY_REG_W  = 6,
    parameter int ARCH_REG_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alloc_valid,
    input  logic                  alloc_has_dst,
    input  logic [ARCH_REG_W-1:0] alloc_arch_rd,
    input  logic [PHY_REG_W-1:0]  alloc_phy_rd,
    output logic [TAG_W-1:0]      alloc_tag,
    output logic                  rob_full,
    output logic                  rob_empty,
    output logic [TAG_W:0]        rob_count,
    input  logic                  cdb_valid,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic [DATA_W-1:0]     cdb_value,
    output logic                  commit_valid,
    output logic                  commit_with_write,
    output logic [ARCH_REG_W-1:0] commit_arch_reg,
    output logic [PHY_REG_W-1:0]  commit_phy_reg_addr,
    output logic [TAG_W-1:0]      commit_tag,
    output logic [DATA_W-1:0]     commit_value
);

    typedef struct packed {
        logic                  has_dst;
        logic [ARCH_REG_W-1:0] arch_rd;
        logic [PHY_REG_W-1:0]  phy_rd;
    } meta_t;

    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    logic [TAG_W:0]       head;
    logic [TAG_W:0]       tail;
    logic [TAG_W-1:0]     head_idx;
    logic [TAG_W-1:0]     tail_idx;
    logic [ROB_DEPTH-1:0] ent_valid;
    logic [ROB_DEPTH-1:0] ent_done;
    meta_t                ent_meta  [ROB_DEPTH];
    logic [DATA_W-1:0]    ent_value [ROB_DEPTH];

    logic alloc_accept;
    logic cdb_hit;
    logic commit_fire;

    assign head_idx  = head[TAG_W-1:0];
    assign tail_idx  = tail[TAG_W-1:0];

    // Wrap bit tells a full ring from an empty one when the indices match.
    assign rob_empty = (head == tail);
    assign rob_full  = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    assign rob_count = tail - head;
    assign alloc_tag = tail_idx;

    assign alloc_accept = alloc_valid & ~rob_full;
    assign cdb_hit      = cdb_valid & ent_valid[cdb_tag] & ~ent_done[cdb_tag];
    // Uses registered done only, so a same-cycle broadcast cannot retire its entry yet.
    assign commit_fire  = ent_valid[head_idx] & ent_done[head_idx];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (alloc_accept) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
                tail                <= tail + PTR_ONE;
            end
            if (cdb_hit) begin
                ent_done[cdb_tag] <= 1'b1;
            end
            if (commit_fire) begin
                ent_valid[head_idx] <= 1'b0;
                head                <= head + PTR_ONE;
            end
        end
    end

    // Payload needs no reset: it is only observed through a valid, done entry.
    always_ff @(posedge clk) begin
        if (alloc_accept) begin
            ent_meta[tail_idx] <= '{has_dst: alloc_has_dst,
                                    arch_rd: alloc_arch_rd,
                                    phy_rd:  alloc_phy_rd};
        end
        if (cdb_hit) begin
            ent_value[cdb_tag] <= cdb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_valid        <= 1'b0;
            commit_with_write   <= 1'b0;
            commit_arch_reg     <= '0;
            commit_phy_reg_addr <= '0;
            commit_tag          <= '0;
            commit_value        <= '0;
        end else if (flush) begin
            commit_valid <= 1'b0;
        end else begin
            commit_valid <= commit_fire;
            if (commit_fire) begin
                commit_with_write   <= ent_meta[head_idx].has_dst;
                commit_arch_reg     <= ent_meta[head_idx].arch_rd;
                commit_phy_reg_addr <= ent_meta[head_idx].phy_rd;
                commit_tag          <= head_idx;
                commit_value        <= ent_value[head_idx];
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: a program-order queue model predicts every retirement and the occupancy flags.
module tb_rob_commit_unit;

    localparam int DEPTH = 16;
    localparam int TW    = 4;
    localparam int PW    = 6;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          alloc_valid;
    logic          alloc_has_dst;
    logic [AW-1:0] alloc_arch_rd;
    logic [PW-1:0] alloc_phy_rd;
    logic [TW-1:0] alloc_tag;
    logic          rob_full;
    logic          rob_empty;
    logic [TW:0]   rob_count;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_value;
    logic          commit_valid;
    logic          commit_with_write;
    logic [AW-1:0] commit_arch_reg;
    logic [PW-1:0] commit_phy_reg_addr;
    logic [TW-1:0] commit_tag;
    logic [DW-1:0] commit_value;

    rob_commit_unit #(
        .ROB_DEPTH(DEPTH), .TAG_W(TW), .PHY_REG_W(PW), .ARCH_REG_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_has_dst(alloc_has_dst),
        .alloc_arch_rd(alloc_arch_rd), .alloc_phy_rd(alloc_phy_rd),
        .alloc_tag(alloc_tag), .rob_full(rob_full), .rob_empty(rob_empty),
        .rob_count(rob_count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .commit_valid(commit_valid),
        .commit_with_write(commit_with_write), .commit_arch_reg(commit_arch_reg),
        .commit_phy_reg_addr(commit_phy_reg_addr), .commit_tag(commit_tag),
        .commit_value(commit_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        bit          has_dst;
        int          arch;
        int          phy;
        bit          done;
        logic [31:0] value;
    } ent_t;

    ent_t m_q[$];
    ent_t exp_q[$];
    int   m_tail = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight instructions in program order; retire when the oldest is done.
    always @(posedge clk) begin : model
        bit was_full;
        ent_t n;
        if (reset || flush) begin
            m_q.delete();
            m_tail = 0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            if (m_q.size() > 0 && m_q[0].done) begin
                exp_q.push_back(m_q[0]);
                void'(m_q.pop_front());
            end
            if (cdb_valid) begin
                foreach (m_q[i]) begin
                    if (m_q[i].tag == int'(cdb_tag) && !m_q[i].done) begin
                        m_q[i].done  = 1'b1;
                        m_q[i].value = cdb_value;
                    end
                end
            end
            if (alloc_valid && !was_full) begin
                n.tag     = m_tail;
                n.has_dst = alloc_has_dst;
                n.arch    = int'(alloc_arch_rd);
                n.phy     = int'(alloc_phy_rd);
                n.done    = 1'b0;
                n.value   = '0;
                m_q.push_back(n);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin : monitor
        ent_t e;
        if (mon_en) begin
            if (commit_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_commit", 64'(commit_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_tag",   64'(commit_tag),          64'(e.tag));
                    chk("commit_write", 64'(commit_with_write),   64'(e.has_dst));
                    chk("commit_arch",  64'(commit_arch_reg),     64'(e.arch));
                    chk("commit_phy",   64'(commit_phy_reg_addr), 64'(e.phy));
                    chk("commit_value", 64'(commit_value),        64'(e.value));
                end
            end
            if (exp_q.size() != 0) begin
                chk("missed_commit", 64'(commit_valid), 64'(1));
                exp_q.delete();
            end
            chk("rob_count", 64'(rob_count), 64'(m_q.size()));
            chk("rob_empty", 64'(rob_empty), 64'(m_q.size() == 0));
            chk("rob_full",  64'(rob_full),  64'(m_q.size() == DEPTH));
            chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
            chk("empty_and_full", 64'(rob_empty & rob_full), 64'(0));
            chk("count_bound",    64'(rob_count <= 5'(DEPTH)), 64'(1));
        end
    end

    task automatic cyc(input bit av, input bit hd, input int ar, input int pr,
                       input bit cv, input int ct, input logic [31:0] cval, input bit fl);
        alloc_valid   = av;
        alloc_has_dst = hd;
        alloc_arch_rd = AW'(ar);
        alloc_phy_rd  = PW'(pr);
        cdb_valid     = cv;
        cdb_tag       = TW'(ct);
        cdb_value     = cval;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pick_pending(output bit ok, output int tag);
        int idx[$];
        foreach (m_q[i]) if (!m_q[i].done) idx.push_back(m_q[i].tag);
        ok  = (idx.size() > 0);
        tag = ok ? idx[$urandom_range(0, idx.size() - 1)] : 0;
    endtask

    task automatic drain();
        bit ok;
        int t;
        for (int i = 0; i < 200; i++) begin
            if (m_q.size() == 0) break;
            pick_pending(ok, t);
            cyc(0, 0, 0, 0, ok, t, $urandom, 0);
        end
        idle(3);
    endtask

    initial begin
        bit ok;
        int t;
        int t0;
        reset = 1'b1;
        flush = 1'b0;
        alloc_valid = 1'b0; alloc_has_dst = 1'b0; alloc_arch_rd = '0; alloc_phy_rd = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        chk("rst_empty", 64'(rob_empty), 64'(1));
        chk("rst_full",  64'(rob_full),  64'(0));
        chk("rst_count", 64'(rob_count), 64'(0));
        chk("rst_tag",   64'(alloc_tag), 64'(0));
        chk("rst_cvalid", 64'(commit_valid), 64'(0));
        chk("rst_cdata", {commit_with_write, commit_arch_reg, commit_phy_reg_addr, commit_tag, commit_value}, 64'(0));

        // Out-of-order completion, in-order retirement.
        cyc(1, 1, 1, 10, 0, 0, 0, 0);
        cyc(1, 1, 2, 11, 0, 0, 0, 0);
        cyc(1, 1, 3, 12, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2, 32'hAAAA0002, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'hAAAA0000, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'hAAAA0001, 0);
        chk("ooo_commit0_tag", 64'(commit_tag), 64'(0));
        idle(4);

        // Fill to capacity; the alloc in the commit cycle is still refused.
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, i + 20, 0, 0, 0, 0);
        chk("fill_full",  64'(rob_full),  64'(1));
        chk("fill_count", 64'(rob_count), 64'(16));
        cyc(1, 1, 9, 40, 1, 0, 32'h1234_0000, 0);
        chk("full_reject_count", 64'(rob_count), 64'(16));
        cyc(1, 1, 9, 41, 0, 0, 0, 0);
        chk("commit_cycle_reject", 64'(rob_count), 64'(15));
        chk("reopen_tag",  64'(alloc_tag), 64'(0));
        cyc(1, 1, 9, 42, 0, 0, 0, 0);
        chk("accept_after", 64'(rob_count), 64'(16));
        drain();

        // 40 pipelined alloc/complete pairs wrap the tags twice.
        t = m_tail;
        cyc(1, 1, 7, 7, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            t0 = m_tail;
            cyc(1, (i % 3) != 0, i % 32, i % 64, 1, t, $urandom, 0);
            t = t0;
        end
        cyc(0, 0, 0, 0, 1, t, $urandom, 0);
        idle(3);

        // Ignored broadcasts: unallocated tag, then duplicates to a done entry.
        cyc(0, 0, 0, 0, 1, 5, 32'hDEAD0005, 0);
        t0 = m_tail;
        t  = (t0 + 1) % DEPTH;
        cyc(1, 1, 4, 30, 0, 0, 0, 0);
        cyc(1, 1, 5, 31, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, t,  32'h1111_1111, 0);
        cyc(0, 0, 0, 0, 1, t,  32'h2222_2222, 0);
        cyc(0, 0, 0, 0, 1, t0, 32'h3333_3333, 0);
        cyc(0, 0, 0, 0, 1, t0, 32'h4444_4444, 0);
        chk("dup_first_value", 64'(commit_value), 64'(32'h3333_3333));
        idle(3);
        chk("dup_second_value", 64'(commit_value), 64'(32'h1111_1111));

        // Flush with alloc, CDB and a ready commit all in the same cycle.
        t0 = m_tail;
        for (int i = 0; i < 4; i++) cyc(1, 1, i + 8, i + 50, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, (t0 + 1) % DEPTH, 32'h5555_0001, 0);
        cyc(0, 0, 0, 0, 1, t0, 32'h5555_0000, 0);
        cyc(1, 1, 1, 1, 1, (t0 + 2) % DEPTH, 32'h5555_0002, 1);
        chk("flush_empty",  64'(rob_empty),    64'(1));
        chk("flush_count",  64'(rob_count),    64'(0));
        chk("flush_tag",    64'(alloc_tag),    64'(0));
        chk("flush_cvalid", 64'(commit_valid), 64'(0));
        idle(5);

        // No destination register.
        cyc(1, 0, 6, 33, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h0BAD_F00D, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("nodst_valid", 64'(commit_valid),      64'(1));
        chk("nodst_write", 64'(commit_with_write), 64'(0));
        idle(2);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            pick_pending(ok, t);
            if ($urandom_range(0, 3) == 0) t = $urandom_range(0, DEPTH - 1);
            cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                $urandom_range(0, 31), $urandom_range(0, 63),
                ($urandom_range(0, 2) != 0), t, $urandom,
                ($urandom_range(0, 63) == 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
